instr_fetch_unit: RTL and testbench

- Instruction fetch front-end for the 16-bit CPU. It drives the instruction-memory request port and buffers returned words in a small FIFO.
- Presents one 16-bit instruction word at a time, with valid/ready, to the opcode decoder.
- Handles PC sequencing, redirect (branch/jump) flush, and discard of stale in-flight responses.

---
 rtl/instr_fetch_unit_if.sv | 22 ++
 rtl/instr_fetch_unit.sv | 97 +++++++++
 tb/tb_instr_fetch_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory request/response, redirect and decoder handshake bundle
interface instr_fetch_unit_if #(parameter int ADDR_W = 8);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [15:0]       imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [15:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              instr_illegal;
  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, instr_illegal,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, instr_illegal,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencer, single-outstanding imem requester and {pc,word} FIFO; ILLEGAL_CHK_EN adds halt on opcode 4'hF
module instr_fetch_unit #(
  parameter int                ADDR_W    = 8,
  parameter int                BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_DROP
`ifdef ILLEGAL_CHK_EN
    , S_HALT
`endif
  } state_t;
  state_t            state, state_n, done_state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W:0]    count;
  logic [PTR_W+1:0]  fill;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] buf_pc [BUF_DEPTH];
  logic [15:0]       buf_word [BUF_DEPTH];
  logic              valid, busy, resp, push, pop, halt_push, issue;
  assign valid = count != '0;
  assign busy  = state == S_WAIT || state == S_DROP;
  assign resp  = busy && bus.imem_rvalid;
  assign push  = state == S_WAIT && bus.imem_rvalid && !bus.redirect;
  assign pop   = valid && bus.instr_ready && !bus.redirect;
  assign fill  = {1'b0, count} + (PTR_W+2)'(push) - (PTR_W+2)'(pop);
`ifdef ILLEGAL_CHK_EN
  assign halt_push  = push && bus.imem_rdata[15:12] == 4'hF;
  assign done_state = halt_push ? S_HALT : S_IDLE;
`else
  assign halt_push  = 1'b0;
  assign done_state = S_IDLE;
`endif
  // a new request only goes out once the slot it will fill is guaranteed free
  assign issue = !bus.redirect && !halt_push && (state == S_IDLE || resp) && fill < (PTR_W+2)'(BUF_DEPTH);
  // next state: redirect turns an unanswered request stale, otherwise follow issue/response
  always_comb begin
    state_n = bus.redirect ? ((busy && !bus.imem_rvalid) ? S_DROP : S_IDLE) :
              issue ? S_WAIT : resp ? done_state : state;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  // fetch PC sequencing and registered request; imem_addr holds the PC of the outstanding request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc      <= RESET_PC;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= RESET_PC;
    end else begin
      bus.imem_req <= issue;
      if (issue) bus.imem_addr <= fetch_pc;
      fetch_pc <= bus.redirect ? bus.redirect_pc : issue ? fetch_pc + 1'b1 : fetch_pc;
    end
  // instruction buffer: redirect flushes, otherwise push returned words and pop accepted ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]   <= '0;
        buf_word[i] <= '0;
      end
    end else if (bus.redirect) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        buf_pc[wr_ptr]   <= bus.imem_addr;
        buf_word[wr_ptr] <= bus.imem_rdata;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  assign bus.instr       = buf_word[rd_ptr];
  assign bus.instr_pc    = buf_pc[rd_ptr];
  assign bus.instr_valid = valid;
`ifdef ILLEGAL_CHK_EN
  logic buf_ill [BUF_DEPTH];
  // per-entry illegal-opcode flag captured alongside the word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < BUF_DEPTH; i++) buf_ill[i] <= 1'b0;
    else if (push) buf_ill[wr_ptr] <= bus.imem_rdata[15:12] == 4'hF;
  assign bus.instr_illegal = buf_ill[rd_ptr];
`else
  assign bus.instr_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of sequencing, backpressure, redirect/drop, PC wrap and illegal-opcode handling
module tb_instr_fetch_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         n_cmp = 0, n_bad = 0, n;
  logic [7:0] slow_addr = 8'h7F;
  bit         ill_mode = 1'b0;
  bit         pend = 1'b0;
  int         pend_cnt = 0;
  logic [7:0] pend_addr = '0;
  instr_fetch_unit_if #(.ADDR_W(8)) bus ();
  instr_fetch_unit #(.ADDR_W(8), .BUF_DEPTH(2), .RESET_PC(8'h00)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] word_at(logic [7:0] a);
    return (ill_mode && a == 8'd3) ? 16'hF123 : 16'h1000 + {8'h00, a};
  endfunction
  // memory model: one pending read, latency 1 cycle (3 cycles for slow_addr)
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      if (!rst_n) pend = 1'b0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = word_at(pend_addr);
          pend = 1'b0;
        end
      end
      if (rst_n && bus.imem_req) begin
        pend      = 1'b1;
        pend_cnt  = (bus.imem_addr == slow_addr) ? 3 : 1;
        pend_addr = bus.imem_addr;
      end
    end
  end
  task automatic step(int k = 1);
    repeat (k) @(negedge clk);
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_req(string tag, logic r, logic [7:0] a);
    chk(tag, {23'h0, bus.imem_req, bus.imem_addr}, {23'h0, r, a});
  endtask
  task automatic chk_head(string tag, logic [15:0] w, logic [7:0] p);
    chk({tag, "_valid"}, {31'h0, bus.instr_valid}, 32'h1);
    chk({tag, "_instr"}, {16'h0, bus.instr}, {16'h0, w});
    chk({tag, "_pc"}, {24'h0, bus.instr_pc}, {24'h0, p});
  endtask
  task automatic chk_empty(string tag);
    chk(tag, {31'h0, bus.instr_valid}, 32'h0);
  endtask
  task automatic wait_req(logic [7:0] a, string tag);
    int k = 0;
    while (!(bus.imem_req === 1'b1 && bus.imem_addr === a) && k < 40) begin
      step();
      k++;
    end
    chk_req(tag, 1'b1, a);
  endtask
  task automatic reset_pulse();
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask
  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b1;
    step(2);
    chk_req("rst_req", 1'b0, 8'h00);
    chk("rst_instr", {16'h0, bus.instr}, 32'h0);
    chk("rst_pc", {24'h0, bus.instr_pc}, 32'h0);
    chk_empty("rst_valid");
    chk("rst_illegal", {31'h0, bus.instr_illegal}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_req(8'(i), "seq_req");
      step(2);
      chk_head("seq", 16'h1000 + 16'(i), 8'(i));
    end
    rst_n = 1'b0;
    bus.instr_ready = 1'b0;
    #1;
    chk_empty("async_rst_valid");
    chk("async_rst_req", {31'h0, bus.imem_req}, 32'h0);
    step(3);
    rst_n = 1'b1;
    n = 0;
    repeat (14) begin
      step();
      if (bus.imem_req) n++;
    end
    chk("bp_req_count", n, 2);
    chk_head("bp_hold", 16'h1000, 8'h00);
    bus.instr_ready = 1'b1;
    step();
    chk_head("bp_drain1", 16'h1001, 8'h01);
    chk_req("bp_resume", 1'b1, 8'h02);
    step(2);
    chk_head("bp_next", 16'h1002, 8'h02);
    slow_addr = 8'h05;
    reset_pulse();
    wait_req(8'h05, "drop_req5");
    bus.instr_ready = 1'b0;
    step();
    chk_head("drop_before", 16'h1004, 8'h04);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h40;
    step();
    bus.redirect    = 1'b0;
    bus.instr_ready = 1'b1;
    chk_empty("drop_flush");
    chk("drop_noreq1", {31'h0, bus.imem_req}, 32'h0);
    step();
    chk_empty("drop_stale");
    chk("drop_noreq2", {31'h0, bus.imem_req}, 32'h0);
    step();
    chk_req("drop_newreq", 1'b1, 8'h40);
    chk_empty("drop_discard");
    step(2);
    chk_head("drop_first", 16'h1040, 8'h40);
    bus.instr_ready = 1'b0;
    step();
    chk_head("rv_hold", 16'h1040, 8'h40);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h20;
    bus.instr_ready = 1'b1;
    step();
    bus.redirect = 1'b0;
    chk_empty("rv_flush");
    chk("rv_noreq", {31'h0, bus.imem_req}, 32'h0);
    step();
    chk_req("rv_newreq", 1'b1, 8'h20);
    chk_empty("rv_dropped");
    step(2);
    chk_head("rv_first", 16'h1020, 8'h20);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'hFF;
    step();
    bus.redirect = 1'b0;
    chk_empty("wrap_flush");
    step();
    chk_req("wrap_reqff", 1'b1, 8'hFF);
    step(2);
    chk_head("wrap_ff", 16'h10FF, 8'hFF);
    chk_req("wrap_req00", 1'b1, 8'h00);
    step(2);
    chk_head("wrap_00", 16'h1000, 8'h00);
    slow_addr = 8'h7F;
    ill_mode  = 1'b1;
    reset_pulse();
    wait_req(8'h03, "ill_req3");
    step(2);
    chk_head("ill_head", 16'hF123, 8'h03);
`ifdef ILLEGAL_CHK_EN
    chk("ill_flag", {31'h0, bus.instr_illegal}, 32'h1);
    chk_req("ill_halt", 1'b0, 8'h03);
`else
    chk("ill_flag", {31'h0, bus.instr_illegal}, 32'h0);
    chk_req("ill_cont", 1'b1, 8'h04);
`endif
    n = 0;
    repeat (5) begin
      step();
      if (bus.imem_req) n++;
    end
`ifdef ILLEGAL_CHK_EN
    chk("ill_req_count", n, 0);
`else
    chk("ill_req_count", n, 2);
`endif
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h10;
    step();
    bus.redirect = 1'b0;
    chk_empty("ill_flush");
    step();
    chk_req("ill_resume", 1'b1, 8'h10);
    step(2);
    chk_head("ill_after", 16'h1010, 8'h10);
    chk("ill_after_flag", {31'h0, bus.instr_illegal}, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
